// File: rtl/uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// uart_tx_feeder
//   Word-to-byte sequencer that sits in front of uart_tx. Input words are
//   queued in a small FIFO and streamed out MSB byte first, one uart_tx
//   frame per byte. The feeder paces itself on uart_tx's tx_active/tx_done
//   and never raises tx_start while the transmitter reports busy.
//
//   Build option: define UART_TX_FEEDER_EOL_EN to follow every word with a
//   CR (8'h0D) and LF (8'h0A) frame. Without it a word is exactly
//   WORD_BYTES frames and no end-of-line logic exists in the netlist.
// ---------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int WORD_BYTES = 4,   // bytes per input word (>=1)
    parameter int DEPTH      = 4,   // FIFO depth in words, power of two
    parameter int ADDR_W     = 2    // log2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,        // asynchronous, active-high
    // word input
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [8*WORD_BYTES-1:0] wr_word,
    // uart_tx side
    output logic                    tx_start,   // one-cycle frame request
    output logic [7:0]              tx_byte,    // held from tx_start to tx_done
    input  logic                    tx_done,    // frame-complete pulse
    input  logic                    tx_active,  // transmitter busy
    // status
    output logic                    word_done,  // last frame of a word finished
    output logic [ADDR_W:0]         count,      // words waiting in the FIFO
    output logic                    busy
);

    localparam int WORD_W = 8 * WORD_BYTES;

`ifdef UART_TX_FEEDER_EOL_EN
    localparam int FRAMES = WORD_BYTES + 2;
`else
    localparam int FRAMES = WORD_BYTES;
`endif

    // byte_idx runs 0..FRAMES-1; one spare bit keeps the width legal when FRAMES==1
    localparam int IDX_W = $clog2(FRAMES) + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAMES - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // nothing loaded in the shift register
        ARM  = 2'd1,   // byte loaded, waiting for the transmitter to be free
        SEND = 2'd2    // frame requested, waiting for tx_done
    } state_e;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [WORD_W-1:0]   shreg_q,     shreg_d;
    logic [IDX_W-1:0]    byte_idx_q,  byte_idx_d;
    logic                tx_start_q,  tx_start_d;
    logic                word_done_q, word_done_d;
    logic [ADDR_W:0]     count_q,     count_d;
    logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q,    rd_ptr_d;
    logic                wr_ready_q;

    logic [WORD_W-1:0]   mem [DEPTH];

    logic                push;
    logic                pop;
    logic [WORD_W-1:0]   shreg_next;   // shift-register contents for the following frame

    // wr_ready comes from a register, so a pop in this cycle cannot free a slot for this cycle's write
    assign push = wr_valid & wr_ready_q;

    // ---------------------------------------------------------------------
    // Word storage: written only on an accepted push
    // ---------------------------------------------------------------------
    // NOTE: the word array is deliberately left out of reset; count and the
    // pointers alone decide which entries are live, so clearing them flushes
    // the FIFO and the array can map onto plain RAM/flops without a reset net.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_word;
        end
    end

    // ---------------------------------------------------------------------
    // Next byte to present after a completed frame
    // ---------------------------------------------------------------------
`ifdef UART_TX_FEEDER_EOL_EN
    localparam logic [IDX_W-1:0] DATA_LAST_IDX = IDX_W'(WORD_BYTES - 1);
    localparam logic [IDX_W-1:0] CR_IDX        = IDX_W'(WORD_BYTES);

    // Shift the data out, then substitute CR and LF after the last data byte
    always_comb begin
        shreg_next = shreg_q << 8;
        if (byte_idx_q == DATA_LAST_IDX) begin
            shreg_next[WORD_W-1 -: 8] = 8'h0D;
        end else if (byte_idx_q == CR_IDX) begin
            shreg_next[WORD_W-1 -: 8] = 8'h0A;
        end
    end
`else
    // Plain MSB-first shift
    assign shreg_next = shreg_q << 8;
`endif

    // ---------------------------------------------------------------------
    // Sequencer next-state and registered-output logic
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case
    // statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        byte_idx_d  = byte_idx_q;
        tx_start_d  = 1'b0;
        word_done_d = 1'b0;
        pop         = 1'b0;

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    shreg_d    = mem[rd_ptr_q];
                    byte_idx_d = '0;
                    state_d    = ARM;
                end
            end

            ARM: begin
                // A stale tx_done from a frame started before a reset also blocks the start
                if (!tx_active && !tx_done) begin
                    tx_start_d = 1'b1;
                    state_d    = SEND;
                end
            end

            SEND: begin
                if (tx_done) begin
                    if (byte_idx_q != LAST_IDX) begin
                        shreg_d    = shreg_next;
                        byte_idx_d = byte_idx_q + IDX_ONE;
                        state_d    = ARM;
                    end else begin
                        word_done_d = 1'b1;
                        if (count_q != '0) begin
                            // chain straight into the next word without visiting IDLE
                            pop        = 1'b1;
                            shreg_d    = mem[rd_ptr_q];
                            byte_idx_d = '0;
                            state_d    = ARM;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FIFO pointer and occupancy update
    // ---------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;   // idle, or push and pop cancel out
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values computed above, independent of the order
    // of statements or processes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            byte_idx_q  <= '0;
            tx_start_q  <= 1'b0;
            word_done_q <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            byte_idx_q  <= byte_idx_d;
            tx_start_q  <= tx_start_d;
            word_done_q <= word_done_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            // tracks (count_q < DEPTH) one edge ahead, and stays low while in reset
            wr_ready_q  <= (count_d < FULL_CNT);
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign wr_ready  = wr_ready_q;
    assign tx_start  = tx_start_q;
    assign tx_byte   = shreg_q[WORD_W-1 -: 8];
    assign word_done = word_done_q;
    assign count     = count_q;
    assign busy      = (state_q != IDLE) | (count_q != '0);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_feeder
//   Directed bench for uart_tx_feeder with a behavioural uart_tx stand-in:
//   on tx_start it holds tx_active for 100 cycles, then pulses tx_done.
//   The stand-in has no reset, like the real transmitter.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_feeder;

    localparam int WORD_BYTES = 4;
    localparam int DEPTH      = 4;
    localparam int ADDR_W     = 2;
    localparam int ACTIVE_CYC = 100;
`ifdef UART_TX_FEEDER_EOL_EN
    localparam int FRAMES = WORD_BYTES + 2;
`else
    localparam int FRAMES = WORD_BYTES;
`endif
    localparam int WORD_BUDGET = FRAMES * (ACTIVE_CYC + 10) + 50;

    logic              clk;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [31:0]       wr_word;
    logic              tx_start;
    logic [7:0]        tx_byte;
    logic              tx_done;
    logic              tx_active;
    logic              word_done;
    logic [ADDR_W:0]   count;
    logic              busy;

    uart_tx_feeder #(
        .WORD_BYTES (WORD_BYTES),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_word   (wr_word),
        .tx_start  (tx_start),
        .tx_byte   (tx_byte),
        .tx_done   (tx_done),
        .tx_active (tx_active),
        .word_done (word_done),
        .count     (count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // ---------------- transmitter stand-in ----------------
    logic m_active    = 1'b0;
    logic m_done      = 1'b0;
    logic hold_active = 1'b0;   // forces tx_active high from the test sequence
    int   m_cnt       = 0;

    assign tx_active = m_active | hold_active;
    assign tx_done   = m_done;

    initial begin
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (m_active) begin
                if (m_cnt == ACTIVE_CYC - 1) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else begin
                    m_cnt++;
                end
            end else if (tx_start) begin
                m_active = 1'b1;
                m_cnt    = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic       act_at_edge = 1'b0;   // tx_active as seen by the DUT at the last rising edge
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         wd_cnt      = 0;
    int         wd_starts   = 0;      // frames started when word_done was last seen
    int         overlap_cnt = 0;

    always @(posedge clk) act_at_edge <= tx_active;

    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                got_q.push_back(tx_byte);
                if (act_at_edge) overlap_cnt++;
            end
            if (word_done) begin
                wd_cnt++;
                wd_starts = got_q.size();
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add_eol();
`ifdef UART_TX_FEEDER_EOL_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic add_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        add_eol();
    endtask

    // Called just after a falling edge; returns on the falling edge after acceptance.
    task automatic push(input logic [31:0] w);
        int n = 0;
        wr_valid = 1'b1;
        wr_word  = w;
        while (wr_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("push accepted within budget", 32'(n < 2000), 1);
        @(negedge clk);
    endtask

    task automatic wait_wd(input int target, input int limit, input string name);
        int n = 0;
        while (wd_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, " word_done within budget"}, 32'(wd_cnt >= target), 1);
    endtask

    task automatic wait_starts(input int target, input int limit, input string name);
        int n = 0;
        while (got_q.size() < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({name, " frames started within budget"}, 32'(got_q.size() >= target), 1);
    endtask

    task automatic check_bytes(input string name);
        logic [7:0] g;
        check({name, " frame count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("%s byte %0d", name, i), g, exp_q[i]);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [31:0] word;
        logic [7:0]  b0, b1, b2, b3;   // expected data frames, in send order
    } vec_t;

    vec_t vecs [4];

    // ---------------- main sequence ----------------
    initial begin : main
        int wd0;
        int seen;
        logic [31:0] burst [5];

        vecs[0] = '{32'hA1B2C3D4, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        vecs[1] = '{32'h00000001, 8'h00, 8'h00, 8'h00, 8'h01};
        vecs[2] = '{32'hFFFF0080, 8'hFF, 8'hFF, 8'h00, 8'h80};
        vecs[3] = '{32'h5A0F3CC3, 8'h5A, 8'h0F, 8'h3C, 8'hC3};

        burst[0] = 32'h01020304;
        burst[1] = 32'h11121314;
        burst[2] = 32'h21222324;
        burst[3] = 32'h31323334;
        burst[4] = 32'h41424344;

        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_word  = '0;

        // ---- reset held 5 cycles ----
        repeat (5) @(negedge clk);
        check("rst tx_start",  tx_start,  0);
        check("rst tx_byte",   tx_byte,   8'h00);
        check("rst word_done", word_done, 0);
        check("rst busy",      busy,      0);
        check("rst wr_ready",  wr_ready,  0);
        check("rst count",     count,     0);
        rst = 1'b0;
        @(negedge clk);
        check("wr_ready after release", wr_ready, 1);

        // ---- single word, start latency ----
        got_q.delete();
        exp_q.delete();
        add_word(32'hA1B2C3D4);
        wd0 = wd_cnt;
        wr_valid = 1'b1;
        wr_word  = 32'hA1B2C3D4;
        @(negedge clk);                       // accepted at edge C0
        wr_valid = 1'b0;
        check("lat C0 tx_start", tx_start, 0);
        check("lat C0 count",    count,    1);
        @(negedge clk);                       // C1: popped into the shift register
        check("lat C1 tx_start", tx_start, 0);
        check("lat C1 count",    count,    0);
        check("lat C1 busy",     busy,     1);
        @(negedge clk);                       // C2
        check("lat C2 tx_start", tx_start, 1);
        check("lat C2 tx_byte",  tx_byte,  8'hA1);
        @(negedge clk);                       // C3: pulse is one cycle wide
        check("lat C3 tx_start", tx_start, 0);
        wait_wd(wd0 + 1, WORD_BUDGET, "single");
        check_bytes("single");
        check("single word_done after last frame", wd_starts, FRAMES);
        @(negedge clk);
        check("single word_done count", wd_cnt - wd0, 1);
        check("single busy idle", busy, 0);
        check("single word_done low", word_done, 0);

        // ---- table of single words ----
        for (int i = 0; i < 4; i++) begin
            got_q.delete();
            exp_q.delete();
            exp_q.push_back(vecs[i].b0);
            exp_q.push_back(vecs[i].b1);
            exp_q.push_back(vecs[i].b2);
            exp_q.push_back(vecs[i].b3);
            add_eol();
            wd0 = wd_cnt;
            push(vecs[i].word);
            wr_valid = 1'b0;
            wait_wd(wd0 + 1, WORD_BUDGET, $sformatf("vec%0d", i));
            repeat (2) @(negedge clk);
            check_bytes($sformatf("vec%0d", i));
            check($sformatf("vec%0d word_done at last frame", i), wd_starts, FRAMES);
            check($sformatf("vec%0d word_done count", i), wd_cnt - wd0, 1);
            check($sformatf("vec%0d busy idle", i), busy, 0);
        end

        // ---- five back-to-back writes, then a blocked write while full ----
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 5; i++) add_word(burst[i]);
        wd0 = wd_cnt;
        for (int i = 0; i < 5; i++) push(burst[i]);
        check("burst count full", count, 4);
        check("burst wr_ready full", wr_ready, 0);
        wr_word = 32'hDEADBEEF;                // must be ignored: FIFO is full
        repeat (3) @(negedge clk);
        wr_valid = 1'b0;
        check("burst count unchanged by refused write", count, 4);
        wait_wd(wd0 + 5, 5 * WORD_BUDGET, "burst");
        repeat (2) @(negedge clk);
        check_bytes("burst");
        check("burst word_done count", wd_cnt - wd0, 5);
        check("burst no start during tx_active", overlap_cnt, 0);
        check("burst busy idle", busy, 0);

        // ---- tx_active held while a word is pending ----
        got_q.delete();
        exp_q.delete();
        add_word(32'h9ABCDEF0);
        wd0 = wd_cnt;
        hold_active = 1'b1;
        push(32'h9ABCDEF0);
        wr_valid = 1'b0;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (tx_start) seen++;
        end
        check("hold no tx_start while active", seen, 0);
        check("hold busy", busy, 1);
        hold_active = 1'b0;
        @(negedge clk);
        check("hold tx_start after release", tx_start, 1);
        @(negedge clk);
        check("hold tx_start single pulse", tx_start, 0);
        wait_wd(wd0 + 1, WORD_BUDGET, "hold");
        check_bytes("hold");

        // ---- reset during the 2nd frame of a word ----
        got_q.delete();
        exp_q.delete();
        wd0 = wd_cnt;
        push(32'h11223344);
        wr_valid = 1'b0;
        wait_starts(2, 2 * WORD_BUDGET, "midrst");
        push(32'h55667788);
        push(32'h99AABBCC);
        wr_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrst count before reset", count, 2);
        rst = 1'b1;
        #1;
        check("midrst count",     count,    0);
        check("midrst busy",      busy,     0);
        check("midrst tx_start",  tx_start, 0);
        check("midrst tx_byte",   tx_byte,  8'h00);
        check("midrst wr_ready",  wr_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst no word_done for aborted word", wd_cnt - wd0, 0);
        got_q.delete();
        exp_q.delete();
        add_word(32'hCAFEF00D);
        push(32'hCAFEF00D);
        wr_valid = 1'b0;
        wait_wd(wd0 + 1, 2 * WORD_BUDGET, "midrst");
        repeat (2) @(negedge clk);
        check_bytes("midrst");
        check("midrst word_done count", wd_cnt - wd0, 1);
        check("midrst no start during tx_active", overlap_cnt, 0);
        check("midrst busy idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard stop if the sequence ever stalls outside a bounded wait
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1);
    end

endmodule
